// File: rtl/tw_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tw_cmd_decoder
//
// Protocol layer sitting between the FT2232H FIFO byte interface and the
// three-wire (3W) master. Host command bytes are parsed into PING, ECHO, READ
// and WRITE frames. READ and WRITE frames issue one 3W transaction each. Every
// frame produces response bytes, which are serialised back to the FIFO
// transmit side.
//
// Frames (host -> decoder : decoder -> host)
//   PING  : 01                    : A5
//   ECHO  : 02, b                 : b
//   READ  : 03, addr              : DATA_BYTES of read data
//   WRITE : 04, addr, data        : A5
//   other : op                    : EE
// The address is sent MSB-first. Data is sent LSB-first in both directions.
//
// Parameters
//   ADDRESS_BITS       3W address width
//   DATA_BITS          3W data width
//   RX_TIMEOUT_CYCLES  idle cycles allowed between bytes of one command
//
// Ports
//   in_clk          system clock
//   in_reset        asynchronous active-high reset
//   in_rx_data      command byte from the FIFO receive side
//   in_rx_valid     in_rx_data is valid
//   out_rx_ready    decoder accepts a byte this cycle
//   out_tx_data     response byte to the FIFO transmit side
//   out_tx_valid    out_tx_data is valid
//   in_tx_ready     transmit side accepts the byte this cycle
//   out_tw_start    one-cycle pulse that starts a 3W transaction
//   out_tw_wr       1 = write, 0 = read; stable from start until done
//   out_tw_addr     3W address; stable from start until done
//   out_tw_wr_data  3W write data; stable from start until done
//   in_tw_rd_data   read data, valid while in_tw_done is high
//   in_tw_done      one-cycle pulse marking the end of the 3W transaction
// -----------------------------------------------------------------------------
module tw_cmd_decoder #(
  parameter int ADDRESS_BITS      = 16,
  parameter int DATA_BITS         = 32,
  parameter int RX_TIMEOUT_CYCLES = 65535
) (
  input  logic                    in_clk,
  input  logic                    in_reset,
  input  logic [7:0]              in_rx_data,
  input  logic                    in_rx_valid,
  output logic                    out_rx_ready,
  output logic [7:0]              out_tx_data,
  output logic                    out_tx_valid,
  input  logic                    in_tx_ready,
  output logic                    out_tw_start,
  output logic                    out_tw_wr,
  output logic [ADDRESS_BITS-1:0] out_tw_addr,
  output logic [DATA_BITS-1:0]    out_tw_wr_data,
  input  logic [DATA_BITS-1:0]    in_tw_rd_data,
  input  logic                    in_tw_done
);

  localparam int ADDR_BYTES = (ADDRESS_BITS + 7) / 8;
  localparam int DATA_BYTES = (DATA_BITS + 7) / 8;
  localparam int ADDR_W8    = ADDR_BYTES * 8;
  localparam int DATA_W8    = DATA_BYTES * 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W      = $clog2(MAX_BYTES + 1);
  localparam int TO_W       = $clog2(RX_TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_PING  = 8'h01;
  localparam logic [7:0] OP_ECHO  = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h04;
  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_NAK  = 8'hEE;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RX_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ECHO,
    GET_ADDR,
    GET_DATA,
    TW_START,
    TW_WAIT,
    SEND
  } state_t;

  state_t             state;
  state_t             next_state;

  logic               rx_enable;
  logic               is_write;
  logic [CNT_W-1:0]   byte_cnt;
  logic [TO_W-1:0]    idle_cnt;
  logic [ADDR_W8-1:0] addr_shift;
  logic [DATA_W8-1:0] data_shift;
  logic [DATA_W8-1:0] tx_shift;
  logic [CNT_W-1:0]   tx_left;

  logic               rx_fire;
  logic               tx_fire;
  logic               rx_timeout;

  assign rx_fire    = in_rx_valid & out_rx_ready;
  assign tx_fire    = out_tx_valid & in_tx_ready;
  // The idle counter only runs in the receive states, so a match there while
  // no byte arrives means the host went silent mid-command.
  assign rx_timeout = (idle_cnt == TO_LAST) && !rx_fire;

  assign out_tx_data    = tx_shift[7:0];
  assign out_tw_wr      = is_write;
  assign out_tw_addr    = addr_shift[ADDRESS_BITS-1:0];
  assign out_tw_wr_data = data_shift[DATA_BITS-1:0];

  // State register.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the state-decoded handshake outputs.
  // rx_enable keeps out_rx_ready low until the first clock edge after reset.
  always_comb begin
    next_state   = state;
    out_rx_ready = 1'b0;
    out_tx_valid = 1'b0;
    out_tw_start = 1'b0;
    unique case (state)
      IDLE: begin
        out_rx_ready = rx_enable;
        if (rx_fire) begin
          unique case (in_rx_data)
            OP_ECHO:           next_state = GET_ECHO;
            OP_READ, OP_WRITE: next_state = GET_ADDR;
            default:           next_state = SEND;
          endcase
        end
      end
      GET_ECHO: begin
        out_rx_ready = rx_enable;
        if (rx_fire) begin
          next_state = SEND;
        end else if (rx_timeout) begin
          next_state = IDLE;
        end
      end
      GET_ADDR: begin
        out_rx_ready = rx_enable;
        if (rx_fire) begin
          if (byte_cnt == ADDR_LAST) begin
            next_state = is_write ? GET_DATA : TW_START;
          end
        end else if (rx_timeout) begin
          next_state = IDLE;
        end
      end
      GET_DATA: begin
        out_rx_ready = rx_enable;
        if (rx_fire) begin
          if (byte_cnt == DATA_LAST) begin
            next_state = TW_START;
          end
        end else if (rx_timeout) begin
          next_state = IDLE;
        end
      end
      TW_START: begin
        out_tw_start = 1'b1;
        next_state   = TW_WAIT;
      end
      TW_WAIT: begin
        if (in_tw_done) begin
          next_state = SEND;
        end
      end
      SEND: begin
        out_tx_valid = 1'b1;
        if (tx_fire && (tx_left == CNT_W'(1))) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: byte assembly, idle counting, response loading and shifting.
  // The address accumulates MSB-first by shifting left; write data arrives
  // LSB-first so it enters at the top and shifts right. Bits above the
  // configured widths simply fall off at the output slice.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      rx_enable  <= 1'b0;
      is_write   <= 1'b0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      addr_shift <= '0;
      data_shift <= '0;
      tx_shift   <= '0;
      tx_left    <= '0;
    end else begin
      rx_enable <= 1'b1;
      unique case (state)
        IDLE: begin
          if (rx_fire) begin
            is_write   <= (in_rx_data == OP_WRITE);
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            addr_shift <= '0;
            data_shift <= '0;
            if (in_rx_data == OP_PING) begin
              tx_shift <= DATA_W8'(RSP_ACK);
              tx_left  <= CNT_W'(1);
            end else if ((in_rx_data != OP_ECHO) && (in_rx_data != OP_READ) &&
                         (in_rx_data != OP_WRITE)) begin
              tx_shift <= DATA_W8'(RSP_NAK);
              tx_left  <= CNT_W'(1);
            end
          end
        end
        GET_ECHO: begin
          if (rx_fire) begin
            tx_shift <= DATA_W8'(in_rx_data);
            tx_left  <= CNT_W'(1);
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
        end
        GET_ADDR: begin
          if (rx_fire) begin
            addr_shift <= (addr_shift << 8) | ADDR_W8'(in_rx_data);
            byte_cnt   <= (byte_cnt == ADDR_LAST) ? '0 : byte_cnt + CNT_W'(1);
            idle_cnt   <= '0;
          end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
        end
        GET_DATA: begin
          if (rx_fire) begin
            data_shift <= (data_shift >> 8) | (DATA_W8'(in_rx_data) << (DATA_W8 - 8));
            byte_cnt   <= (byte_cnt == DATA_LAST) ? '0 : byte_cnt + CNT_W'(1);
            idle_cnt   <= '0;
          end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
        end
        TW_WAIT: begin
          if (in_tw_done) begin
            if (is_write) begin
              tx_shift <= DATA_W8'(RSP_ACK);
              tx_left  <= CNT_W'(1);
            end else begin
              tx_shift <= DATA_W8'(in_tw_rd_data);
              tx_left  <= CNT_W'(DATA_BYTES);
            end
          end
        end
        SEND: begin
          if (tx_fire) begin
            tx_shift <= tx_shift >> 8;
            tx_left  <= tx_left - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
